// File: rtl/fanout_fork_if.sv
// Stream bundle for fanout_fork: one upstream valid/ready channel and a
// broadcast head token with per-destination valid/ready.
interface fanout_fork_if #(
    parameter int unsigned NUM_OUT = 7,
    parameter int unsigned DATA_W  = 17
);
    logic [DATA_W-1:0]  in_data;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  out_data;
    logic [NUM_OUT-1:0] out_valid;
    logic [NUM_OUT-1:0] out_ready;

    // Producer/consumer side (drives the upstream token and the downstream readies)
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    // Fork side
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/fanout_fork.sv
// Buffered fanout fork: each token is delivered once to every selected
// destination; per-destination done bits let fast consumers proceed
// independently, and upstream ready depends only on buffer occupancy.
module fanout_fork #(
    parameter int unsigned NUM_OUT = 7,
    parameter int unsigned DATA_W  = 17,
    parameter int unsigned DEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic [NUM_OUT-1:0] cfg_en,
    input  logic [NUM_OUT-1:0] cfg_sel,
    fanout_fork_if.slave       bus,
    output logic               busy
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [NUM_OUT-1:0] done;
    logic [NUM_OUT-1:0] mask;
    logic [NUM_OUT-1:0] fire;
    logic               push;
    logic               retire;

    // Handshake decode; ready/valid come from state, mask and flush only
    always_comb begin
        mask          = cfg_en & cfg_sel;
        busy          = (count != '0);
        bus.in_ready  = (count < CNT_W'(DEPTH)) & ~flush & rst_n;
        bus.out_valid = {NUM_OUT{busy}} & mask & ~done;
        bus.out_data  = mem[rd_ptr];
        fire          = bus.out_valid & bus.out_ready;
        push          = bus.in_valid & bus.in_ready;
        // Head retires once every still-selected output has taken it
        retire        = busy & (&(~mask | done | fire));
    end

    // Occupancy, pointers and per-destination delivery tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            done   <= '0;
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            done   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (retire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                done   <= '0;
            end else begin
                done   <= done | fire;
            end
            count <= count + CNT_W'(push) - CNT_W'(retire);
        end
    end

    // Token storage; push is already suppressed during reset and flush
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end
endmodule

// File: tb/tb_fanout_fork.sv
// Bench for fanout_fork: hand-derived vector table, directed flush/reset
// sequences and randomized traffic against a token-queue reference model.
module tb_fanout_fork;
    localparam int unsigned NUM_OUT = 7;
    localparam int unsigned DATA_W  = 17;
    localparam int unsigned DEPTH   = 2;
    localparam int unsigned N_TOK   = 250;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               flush;
    logic               busy;
    logic [NUM_OUT-1:0] cfg_en;
    logic [NUM_OUT-1:0] cfg_sel;

    fanout_fork_if #(.NUM_OUT(NUM_OUT), .DATA_W(DATA_W)) bus ();

    fanout_fork #(.NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .cfg_en  (cfg_en),
        .cfg_sel (cfg_sel),
        .bus     (bus.slave),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of buffered tokens, each with the set of outputs still owed
    typedef struct {
        logic [DATA_W-1:0]  data;
        logic [NUM_OUT-1:0] pend;
    } ent_t;

    ent_t              mq [$];
    logic [DATA_W-1:0] exp_q [NUM_OUT][$];
    int                deliv [NUM_OUT];

    typedef struct {
        logic [NUM_OUT-1:0] mask;
        logic               vin;
        logic [DATA_W-1:0]  din;
        logic [NUM_OUT-1:0] rdy;
        logic               e_ir;
        logic               e_busy;
        logic [NUM_OUT-1:0] e_ov;
        logic               e_dchk;
        logic [DATA_W-1:0]  e_data;
    } vec_t;

    vec_t tbl [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_busy();
        return (rst_n === 1'b1) && (mq.size() != 0);
    endfunction

    function automatic bit m_in_ready();
        return (rst_n === 1'b1) && (flush !== 1'b1) && (mq.size() < int'(DEPTH));
    endfunction

    function automatic logic [NUM_OUT-1:0] m_ov();
        if (!m_busy()) return '0;
        return cfg_en & cfg_sel & mq[0].pend;
    endfunction

    // Compare DUT against the model and consume deliveries from the per-output scoreboard
    task automatic observe(input bit comb_chk);
        logic [NUM_OUT-1:0] ev;
        logic [NUM_OUT-1:0] sv_rdy;
        logic [NUM_OUT-1:0] sv_ov;
        logic               sv_ir;
        logic               sv_busy;
        ev = m_ov();
        check("in_ready", bus.in_ready, m_in_ready());
        check("busy", busy, m_busy());
        check("out_valid", bus.out_valid, ev);
        if (m_busy()) check("out_data", bus.out_data, mq[0].data);
        for (int i = 0; i < int'(NUM_OUT); i++) begin
            if (bus.out_valid[i] === 1'b1 && bus.out_ready[i] === 1'b1) begin
                deliv[i]++;
                check($sformatf("sb_nonempty[%0d]", i), exp_q[i].size() != 0, 1);
                if (exp_q[i].size() != 0)
                    check($sformatf("sb_data[%0d]", i), bus.out_data, exp_q[i].pop_front());
            end
        end
        if (comb_chk) begin
            sv_rdy  = bus.out_ready;
            sv_ov   = bus.out_valid;
            sv_ir   = bus.in_ready;
            sv_busy = busy;
            bus.out_ready = ~sv_rdy;
            #1;
            check("comb_in_ready", bus.in_ready, sv_ir);
            check("comb_busy", busy, sv_busy);
            check("comb_out_valid", bus.out_valid, sv_ov);
            bus.out_ready = sv_rdy;
            #1;
        end
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_update();
        logic [NUM_OUT-1:0] m;
        logic [NUM_OUT-1:0] f;
        bit                 do_push;
        ent_t               h;
        ent_t               e;
        m = cfg_en & cfg_sel;
        if (rst_n !== 1'b1 || flush === 1'b1) begin
            mq.delete();
            for (int i = 0; i < int'(NUM_OUT); i++) exp_q[i].delete();
            return;
        end
        do_push = (bus.in_valid === 1'b1) && (mq.size() < int'(DEPTH));
        if (mq.size() != 0) begin
            h = mq[0];
            f = m & h.pend & bus.out_ready;
            h.pend = h.pend & ~f;
            mq[0] = h;
            if ((h.pend & m) == '0) void'(mq.pop_front());
        end
        if (do_push) begin
            e.data = bus.in_data;
            e.pend = '1;
            mq.push_back(e);
            for (int i = 0; i < int'(NUM_OUT); i++)
                if (m[i]) exp_q[i].push_back(bus.in_data);
        end
    endtask

    task automatic advance();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input bit comb_chk);
        #1;
        observe(comb_chk);
        advance();
    endtask

    task automatic drive(input logic vin, input logic [DATA_W-1:0] din, input logic [NUM_OUT-1:0] rdy);
        bus.in_valid  = vin;
        bus.in_data   = din;
        bus.out_ready = rdy;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int run_pushed;
        int bound;
        logic [NUM_OUT-1:0] m;

        // Staggered accept, mask 0x05
        tbl.push_back('{7'h05, 1'b1, 17'h011, 7'h00, 1'b1, 1'b0, 7'h00, 1'b0, 17'h000});
        tbl.push_back('{7'h05, 1'b0, 17'h000, 7'h01, 1'b1, 1'b1, 7'h05, 1'b1, 17'h011});
        tbl.push_back('{7'h05, 1'b0, 17'h000, 7'h00, 1'b1, 1'b1, 7'h04, 1'b1, 17'h011});
        tbl.push_back('{7'h05, 1'b0, 17'h000, 7'h04, 1'b1, 1'b1, 7'h04, 1'b1, 17'h011});
        tbl.push_back('{7'h05, 1'b0, 17'h000, 7'h7F, 1'b1, 1'b0, 7'h00, 1'b0, 17'h000});
        // Full buffer, output 1 stalled
        tbl.push_back('{7'h7F, 1'b1, 17'h101, 7'h7D, 1'b1, 1'b0, 7'h00, 1'b0, 17'h000});
        tbl.push_back('{7'h7F, 1'b1, 17'h102, 7'h7D, 1'b1, 1'b1, 7'h7F, 1'b1, 17'h101});
        tbl.push_back('{7'h7F, 1'b1, 17'h103, 7'h7D, 1'b0, 1'b1, 7'h02, 1'b1, 17'h101});
        tbl.push_back('{7'h7F, 1'b1, 17'h103, 7'h7F, 1'b0, 1'b1, 7'h02, 1'b1, 17'h101});
        tbl.push_back('{7'h7F, 1'b1, 17'h103, 7'h7D, 1'b1, 1'b1, 7'h7F, 1'b1, 17'h102});
        tbl.push_back('{7'h7F, 1'b0, 17'h000, 7'h7F, 1'b0, 1'b1, 7'h02, 1'b1, 17'h102});
        tbl.push_back('{7'h7F, 1'b0, 17'h000, 7'h7F, 1'b1, 1'b1, 7'h7F, 1'b1, 17'h103});
        tbl.push_back('{7'h7F, 1'b0, 17'h000, 7'h7F, 1'b1, 1'b0, 7'h00, 1'b0, 17'h000});
        // Empty mask drains one token per cycle
        tbl.push_back('{7'h00, 1'b1, 17'h0AA, 7'h7F, 1'b1, 1'b0, 7'h00, 1'b0, 17'h000});
        tbl.push_back('{7'h00, 1'b1, 17'h0AB, 7'h7F, 1'b1, 1'b1, 7'h00, 1'b1, 17'h0AA});
        tbl.push_back('{7'h00, 1'b1, 17'h0AC, 7'h7F, 1'b1, 1'b1, 7'h00, 1'b1, 17'h0AB});
        tbl.push_back('{7'h00, 1'b1, 17'h0AD, 7'h7F, 1'b1, 1'b1, 7'h00, 1'b1, 17'h0AC});
        tbl.push_back('{7'h00, 1'b0, 17'h000, 7'h7F, 1'b1, 1'b1, 7'h00, 1'b1, 17'h0AD});
        tbl.push_back('{7'h00, 1'b0, 17'h000, 7'h7F, 1'b1, 1'b0, 7'h00, 1'b0, 17'h000});

        for (int i = 0; i < int'(NUM_OUT); i++) deliv[i] = 0;
        rst_n   = 1'b0;
        flush   = 1'b0;
        cfg_en  = '1;
        cfg_sel = '1;
        drive(1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;

        // Outputs held quiet during reset
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_out_valid", bus.out_valid, 0);
        observe(1'b0);
        advance();
        rst_n = 1'b1;
        cyc(1'b0);

        // Vector table
        for (int r = 0; r < tbl.size(); r++) begin
            vec_t v;
            v = tbl[r];
            cfg_sel = v.mask;
            drive(v.vin, v.din, v.rdy);
            #1;
            check($sformatf("tbl%0d_in_ready", r), bus.in_ready, v.e_ir);
            check($sformatf("tbl%0d_busy", r), busy, v.e_busy);
            check($sformatf("tbl%0d_out_valid", r), bus.out_valid, v.e_ov);
            if (v.e_dchk) check($sformatf("tbl%0d_out_data", r), bus.out_data, v.e_data);
            observe(1'b0);
            advance();
        end

        // Broadcast, everything ready: one token per cycle, one cycle latency
        cfg_sel = '1;
        for (int k = 0; k <= 16; k++) begin
            drive(k < 16, DATA_W'(k), '1);
            #1;
            check("bc_in_ready", bus.in_ready, 1);
            if (k > 0) begin
                check("bc_out_valid", bus.out_valid, 7'h7F);
                check("bc_out_data", bus.out_data, k - 1);
            end
            observe(1'b0);
            advance();
        end
        drive(1'b0, '0, '1);
        #1;
        check("bc_idle_busy", busy, 0);
        observe(1'b0);
        advance();

        // Flush after partial delivery of 0xA5
        drive(1'b1, 17'h0A5, '0);
        cyc(1'b0);
        drive(1'b0, '0, 7'h01);
        cyc(1'b0);
        flush = 1'b1;
        drive(1'b1, 17'h077, '0);
        #1;
        check("flush_in_ready", bus.in_ready, 0);
        observe(1'b0);
        advance();
        flush = 1'b0;
        drive(1'b1, 17'h05A, '0);
        #1;
        check("flush_busy", busy, 0);
        check("flush_out_valid", bus.out_valid, 0);
        observe(1'b0);
        advance();
        drive(1'b0, '0, '1);
        #1;
        check("flush_next_ov", bus.out_valid, 7'h7F);
        check("flush_next_data", bus.out_data, 17'h05A);
        observe(1'b0);
        advance();
        cyc(1'b0);

        // Asynchronous reset after partial delivery of 0xA5
        drive(1'b1, 17'h0A5, '0);
        cyc(1'b0);
        drive(1'b0, '0, 7'h01);
        cyc(1'b0);
        rst_n = 1'b0;
        drive(1'b1, 17'h077, '0);
        #1;
        check("mrst_in_ready", bus.in_ready, 0);
        check("mrst_busy", busy, 0);
        check("mrst_out_valid", bus.out_valid, 0);
        observe(1'b0);
        advance();
        rst_n = 1'b1;
        drive(1'b1, 17'h05A, '0);
        #1;
        check("mrst_rel_in_ready", bus.in_ready, 1);
        observe(1'b0);
        advance();
        drive(1'b0, '0, '1);
        #1;
        check("mrst_next_ov", bus.out_valid, 7'h7F);
        check("mrst_next_data", bus.out_data, 17'h05A);
        observe(1'b0);
        advance();
        cyc(1'b0);

        // Randomized runs, mask held per run
        for (int run = 0; run < 4; run++) begin
            cfg_en  = (run == 0) ? '1 : NUM_OUT'($urandom);
            cfg_sel = (run == 0) ? '1 : NUM_OUT'($urandom);
            m = cfg_en & cfg_sel;
            for (int i = 0; i < int'(NUM_OUT); i++) deliv[i] = 0;
            run_pushed = 0;
            bound = 0;
            while (run_pushed < int'(N_TOK) && bound < int'(N_TOK) * 40) begin
                drive($urandom_range(0, 3) != 0, DATA_W'($urandom), NUM_OUT'($urandom));
                if (bus.in_valid && m_in_ready()) run_pushed++;
                bound++;
                cyc($urandom_range(0, 3) == 0);
            end
            check("rand_progress", run_pushed, N_TOK);
            drive(1'b0, '0, '1);
            bound = 0;
            while ((mq.size() != 0 || busy !== 1'b0) && bound < 4 * int'(DEPTH) + 4) begin
                bound++;
                cyc(1'b0);
            end
            #1;
            check("rand_drain_busy", busy, 0);
            for (int i = 0; i < int'(NUM_OUT); i++) begin
                check($sformatf("rand_left[%0d]", i), exp_q[i].size(), 0);
                check($sformatf("rand_count[%0d]", i), deliv[i], m[i] ? N_TOK : 0);
            end
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
